// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl
//   Exception / interrupt arbiter and CP0 register file for a 5-stage MIPS
//   pipeline. Each cycle it picks at most one event by fixed priority,
//   updates BadVAddr/Status/Cause/EPC and issues a one-cycle flush plus
//   redirect pulse. ERET redirects to EPC. It also serves MTC0 writes from WB
//   and combinational MFC0 reads.
//
// Ports
//   clk, reset                    clock, asynchronous active-low reset
//   if_adel, if_pc                fetch address error and its address
//   id_ri/id_sys/id_bp, id_pc     decode-stage exceptions and their PC
//   exe_ov, exe_pc                overflow in EXE and its PC
//   mem_valid, mem_adel, mem_ades MEM-stage live flag and address errors
//   mem_pc, mem_bva, mem_eret     MEM-stage PC, faulting data address, ERET
//   hw_int[5:0]                   level-sensitive external interrupts
//   cp0_wen/addr/sel/wdata        MTC0 write port (from WB)
//   cp0_rdata                     MFC0 read data
//   flush, redirect, redirect_pc  pipeline flush and PC redirect
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_adel,
    input  logic [31:0] if_pc,
    input  logic        id_ri,
    input  logic        id_sys,
    input  logic        id_bp,
    input  logic [31:0] id_pc,
    input  logic        exe_ov,
    input  logic [31:0] exe_pc,
    input  logic        mem_valid,
    input  logic        mem_adel,
    input  logic        mem_ades,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_bva,
    input  logic        mem_eret,
    input  logic [5:0]  hw_int,
    input  logic        cp0_wen,
    input  logic [4:0]  cp0_addr,
    input  logic [2:0]  cp0_sel,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state_reg, state_next;

    logic [31:0] badvaddr_reg, badvaddr_next;
    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg, compare_next;
    logic [31:0] status_reg, status_next;
    logic [31:0] epc_reg, epc_next;
    logic [4:0]  exc_code_reg, exc_code_next;
    logic [1:0]  ip_sw_reg, ip_sw_next;
    logic [5:0]  hw_ip_reg;
    logic        timer_pending_reg, timer_pending_next;
    logic        toggle_reg;

    logic        flush_reg, flush_next;
    logic        redirect_reg, redirect_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;

    logic [7:0]  cause_ip;
    logic [31:0] cause_val;
    logic        int_req;

    logic        exc_take;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bva_we;
    logic [31:0] exc_bva;
    logic        eret_take;

    logic        wr_en;
    logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;

    // IP[7] merges the top hardware line with the internal timer.
    assign cause_ip  = {hw_ip_reg[5] | timer_pending_reg, hw_ip_reg[4:0], ip_sw_reg};
    assign cause_val = {16'h0000, cause_ip, 1'b0, exc_code_reg, 2'b00};

    assign int_req = status_reg[0] & ~status_reg[1]
                   & (|(status_reg[15:8] & cause_ip)) & mem_valid;

    assign wr_en      = cp0_wen & (cp0_sel == 3'd0);
    assign wr_count   = wr_en & (cp0_addr == 5'd9);
    assign wr_compare = wr_en & (cp0_addr == 5'd11);
    assign wr_status  = wr_en & (cp0_addr == 5'd12);
    assign wr_cause   = wr_en & (cp0_addr == 5'd13);
    assign wr_epc     = wr_en & (cp0_addr == 5'd14);

    // Priority selection; everything is ignored in FLUSH because those
    // inputs belong to instructions being squashed.
    always_comb begin
        exc_take   = 1'b0;
        exc_code   = 5'd0;
        exc_epc    = 32'h0;
        exc_bva_we = 1'b0;
        exc_bva    = 32'h0;
        if (state_reg == IDLE) begin
            if (int_req) begin
                exc_take = 1'b1; exc_code = 5'd0;  exc_epc = mem_pc;
            end else if (mem_adel) begin
                exc_take = 1'b1; exc_code = 5'd4;  exc_epc = mem_pc;
                exc_bva_we = 1'b1; exc_bva = mem_bva;
            end else if (mem_ades) begin
                exc_take = 1'b1; exc_code = 5'd5;  exc_epc = mem_pc;
                exc_bva_we = 1'b1; exc_bva = mem_bva;
            end else if (exe_ov) begin
                exc_take = 1'b1; exc_code = 5'd12; exc_epc = exe_pc;
            end else if (id_ri) begin
                exc_take = 1'b1; exc_code = 5'd10; exc_epc = id_pc;
            end else if (id_sys) begin
                exc_take = 1'b1; exc_code = 5'd8;  exc_epc = id_pc;
            end else if (id_bp) begin
                exc_take = 1'b1; exc_code = 5'd9;  exc_epc = id_pc;
            end else if (if_adel) begin
                exc_take = 1'b1; exc_code = 5'd4;  exc_epc = if_pc;
                exc_bva_we = 1'b1; exc_bva = if_pc;
            end
        end
    end

    assign eret_take = (state_reg == IDLE) & ~exc_take & mem_eret;

    // FSM next state and registered pulse outputs.
    always_comb begin
        state_next       = state_reg;
        flush_next       = 1'b0;
        redirect_next    = 1'b0;
        redirect_pc_next = redirect_pc_reg;
        case (state_reg)
            IDLE: begin
                if (exc_take) begin
                    state_next       = FLUSH;
                    flush_next       = 1'b1;
                    redirect_next    = 1'b1;
                    redirect_pc_next = EXC_VECTOR;
                end else if (eret_take) begin
                    state_next       = FLUSH;
                    flush_next       = 1'b1;
                    redirect_next    = 1'b1;
                    // EPC as it was before any MTC0 landing this cycle.
                    redirect_pc_next = epc_reg;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // CP0 register updates: MTC0 first, exception/ERET fields override.
    always_comb begin
        status_next        = status_reg;
        epc_next           = epc_reg;
        badvaddr_next      = badvaddr_reg;
        exc_code_next      = exc_code_reg;
        ip_sw_next         = ip_sw_reg;
        compare_next       = compare_reg;
        count_next         = toggle_reg ? count_reg + 32'd1 : count_reg;
        timer_pending_next = timer_pending_reg;

        if (wr_count)   count_next   = cp0_wdata;
        if (wr_compare) compare_next = cp0_wdata;
        if (wr_status)  status_next  = (status_reg & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
        if (wr_cause)   ip_sw_next   = cp0_wdata[9:8];
        if (wr_epc)     epc_next     = cp0_wdata;

        // Compare write acknowledges the timer; otherwise a match latches it.
        if (wr_compare)
            timer_pending_next = 1'b0;
        else if ((count_reg == compare_reg) && (compare_reg != 32'h0))
            timer_pending_next = 1'b1;

        if (exc_take) begin
            status_next[1] = 1'b1;
            exc_code_next  = exc_code;
            epc_next       = exc_epc;
            if (exc_bva_we) badvaddr_next = exc_bva;
        end else if (eret_take) begin
            status_next[1] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            flush_reg         <= 1'b0;
            redirect_reg      <= 1'b0;
            redirect_pc_reg   <= 32'h0;
            badvaddr_reg      <= 32'h0;
            count_reg         <= 32'h0;
            compare_reg       <= 32'h0;
            status_reg        <= STATUS_RST;
            epc_reg           <= 32'h0;
            exc_code_reg      <= 5'd0;
            ip_sw_reg         <= 2'd0;
            hw_ip_reg         <= 6'd0;
            timer_pending_reg <= 1'b0;
            toggle_reg        <= 1'b0;
        end else begin
            state_reg         <= state_next;
            flush_reg         <= flush_next;
            redirect_reg      <= redirect_next;
            redirect_pc_reg   <= redirect_pc_next;
            badvaddr_reg      <= badvaddr_next;
            count_reg         <= count_next;
            compare_reg       <= compare_next;
            status_reg        <= status_next;
            epc_reg           <= epc_next;
            exc_code_reg      <= exc_code_next;
            ip_sw_reg         <= ip_sw_next;
            hw_ip_reg         <= hw_int;
            timer_pending_reg <= timer_pending_next;
            toggle_reg        <= ~toggle_reg;
        end
    end

    always_comb begin
        cp0_rdata = 32'h0;
        if (cp0_sel == 3'd0) begin
            case (cp0_addr)
                5'd8:    cp0_rdata = badvaddr_reg;
                5'd9:    cp0_rdata = count_reg;
                5'd11:   cp0_rdata = compare_reg;
                5'd12:   cp0_rdata = status_reg;
                5'd13:   cp0_rdata = cause_val;
                5'd14:   cp0_rdata = epc_reg;
                default: cp0_rdata = 32'h0;
            endcase
        end
    end

    assign flush       = flush_reg;
    assign redirect    = redirect_reg;
    assign redirect_pc = redirect_pc_reg;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_adel, id_ri, id_sys, id_bp, exe_ov;
    logic        mem_valid, mem_adel, mem_ades, mem_eret, cp0_wen;
    logic [31:0] if_pc, id_pc, exe_pc, mem_pc, mem_bva, cp0_wdata;
    logic [5:0]  hw_int;
    logic [4:0]  cp0_addr;
    logic [2:0]  cp0_sel;
    logic [31:0] cp0_rdata, redirect_pc;
    logic        flush, redirect;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset),
        .if_adel(if_adel), .if_pc(if_pc),
        .id_ri(id_ri), .id_sys(id_sys), .id_bp(id_bp), .id_pc(id_pc),
        .exe_ov(exe_ov), .exe_pc(exe_pc),
        .mem_valid(mem_valid), .mem_adel(mem_adel), .mem_ades(mem_ades),
        .mem_pc(mem_pc), .mem_bva(mem_bva), .mem_eret(mem_eret),
        .hw_int(hw_int),
        .cp0_wen(cp0_wen), .cp0_addr(cp0_addr), .cp0_sel(cp0_sel),
        .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    // What the DUT must show during one cycle.
    typedef struct packed {
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: architectural CP0 state as named fields.
    logic        m_ie, m_exl, m_tp, m_redirect;
    logic [7:0]  m_im;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_exc;
    logic [5:0]  m_hw;
    logic [31:0] m_epc, m_bva, m_count, m_compare, m_rpc;
    int          m_edges;

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_tp, m_hw[4:0], m_ipsw};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
        if (s != 3'd0) return 32'h0;
        case (a)
            5'd8:  return m_bva;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return 32'h0040_0000 | ({24'h0, m_im} << 8) | {30'h0, m_exl, m_ie};
            5'd13: return ({24'h0, m_ip()} << 8) | ({27'h0, m_exc} << 2);
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_ie = 0; m_exl = 0; m_tp = 0; m_redirect = 0; m_im = 0; m_ipsw = 0;
        m_exc = 0; m_hw = 0; m_epc = 0; m_bva = 0; m_count = 0; m_compare = 0;
        m_rpc = 0; m_edges = 0;
    endtask

    task automatic model_step();
        logic        ireq, take, eret, wr, bset;
        logic [4:0]  code;
        logic [31:0] e_pc, b, old_epc;
        ireq = m_ie && !m_exl && ((m_im & m_ip()) != 8'h0) && mem_valid;
        take = 0; bset = 0; code = 0; e_pc = 0; b = 0;
        if (!m_redirect) begin
            if (ireq)          begin take = 1; code = 0;  e_pc = mem_pc; end
            else if (mem_adel) begin take = 1; code = 4;  e_pc = mem_pc; bset = 1; b = mem_bva; end
            else if (mem_ades) begin take = 1; code = 5;  e_pc = mem_pc; bset = 1; b = mem_bva; end
            else if (exe_ov)   begin take = 1; code = 12; e_pc = exe_pc; end
            else if (id_ri)    begin take = 1; code = 10; e_pc = id_pc; end
            else if (id_sys)   begin take = 1; code = 8;  e_pc = id_pc; end
            else if (id_bp)    begin take = 1; code = 9;  e_pc = id_pc; end
            else if (if_adel)  begin take = 1; code = 4;  e_pc = if_pc; bset = 1; b = if_pc; end
        end
        eret = !m_redirect && !take && mem_eret;
        wr = cp0_wen && (cp0_sel == 3'd0);
        old_epc = m_epc;
        if (wr && cp0_addr == 5'd11) m_tp = 0;
        else if (m_count == m_compare && m_compare != 0) m_tp = 1;
        if (wr && cp0_addr == 5'd9) m_count = cp0_wdata;
        else if (m_edges % 2 == 1) m_count = m_count + 1;
        if (wr && cp0_addr == 5'd11) m_compare = cp0_wdata;
        if (wr && cp0_addr == 5'd12) begin
            m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0];
        end
        if (wr && cp0_addr == 5'd13) m_ipsw = cp0_wdata[9:8];
        if (wr && cp0_addr == 5'd14) m_epc = cp0_wdata;
        m_hw = hw_int;
        if (take) begin
            m_exl = 1; m_exc = code; m_epc = e_pc;
            if (bset) m_bva = b;
            m_rpc = VEC;
        end else if (eret) begin
            m_exl = 0; m_rpc = old_epc;
        end
        m_redirect = take || eret;
        m_edges++;
    endtask

    // Push the expectation for the current cycle, then advance one edge.
    task automatic tick();
        exp_t e;
        if (!reset) model_reset();
        e.redir = m_redirect;
        e.rpc   = m_rpc;
        e.rdata = m_read(cp0_addr, cp0_sel);
        exp_q.push_back(e);
        @(posedge clk);
        if (reset) model_step(); else model_reset();
        cyc++;
        #1;
    endtask

    task automatic clr();
        if_adel = 0; id_ri = 0; id_sys = 0; id_bp = 0; exe_ov = 0;
        mem_valid = 0; mem_adel = 0; mem_ades = 0; mem_eret = 0; cp0_wen = 0;
        if_pc = 0; id_pc = 0; exe_pc = 0; mem_pc = 0; mem_bva = 0;
        cp0_wdata = 0; cp0_addr = 5'd12; cp0_sel = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        clr(); cp0_wen = 1; cp0_addr = a; cp0_wdata = d; tick(); clr();
    endtask

    // Monitor: compares what the DUT presents against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            // idle before the first stimulus; nothing to compare
        end else begin
            e = exp_q.pop_front();
            checks += 4;
            if (redirect !== e.redir) begin
                failures++;
                $display("FAIL redirect cyc=%0d got=%b exp=%b", cyc, redirect, e.redir);
            end
            if (flush !== e.redir) begin
                failures++;
                $display("FAIL flush cyc=%0d got=%b exp=%b", cyc, flush, e.redir);
            end
            if (redirect_pc !== e.rpc) begin
                failures++;
                $display("FAIL redirect_pc cyc=%0d got=%h exp=%h", cyc, redirect_pc, e.rpc);
            end
            if (cp0_rdata !== e.rdata) begin
                failures++;
                $display("FAIL cp0_rdata cyc=%0d addr=%0d sel=%0d got=%h exp=%h",
                         cyc, cp0_addr, cp0_sel, cp0_rdata, e.rdata);
            end
        end
    end

    logic [4:0] addr_tab [8];

    task automatic rand_inputs();
        clr();
        mem_valid = 1'($urandom_range(0, 1));
        if_adel  = ($urandom_range(0, 24) == 0);
        id_ri    = ($urandom_range(0, 24) == 0);
        id_sys   = ($urandom_range(0, 24) == 0);
        id_bp    = ($urandom_range(0, 24) == 0);
        exe_ov   = ($urandom_range(0, 24) == 0);
        mem_adel = ($urandom_range(0, 24) == 0);
        mem_ades = ($urandom_range(0, 24) == 0);
        mem_eret = ($urandom_range(0, 10) == 0);
        if_pc = $urandom & ~32'h3; id_pc = $urandom & ~32'h3;
        exe_pc = $urandom & ~32'h3; mem_pc = $urandom & ~32'h3; mem_bva = $urandom;
        if ($urandom_range(0, 15) == 0) hw_int = 6'($urandom);
        cp0_addr  = addr_tab[$urandom_range(0, 7)];
        cp0_sel   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
        cp0_wen   = ($urandom_range(0, 5) == 0);
        cp0_wdata = $urandom;
        // Status writes mostly re-enable interrupts so they actually fire.
        if (cp0_addr == 5'd12 && $urandom_range(0, 2) != 0) cp0_wdata[1:0] = 2'b01;
    endtask

    initial begin
        addr_tab = '{5'd0, 5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd31};
        clr(); hw_int = 0; reset = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tick();
        reset = 1;
        // Reset state and Count start: reads Status, then Count.
        cp0_addr = 5'd12; tick(); cp0_addr = 5'd9; tick(); tick(); tick();

        // Overflow in EXE, then read Cause/EPC/Status during and after the pulse.
        clr(); exe_ov = 1; exe_pc = 32'h40; tick();
        clr(); cp0_addr = 5'd13; tick(); cp0_addr = 5'd14; tick(); cp0_addr = 5'd12; tick();

        // Store address error beats syscall; syscall held into FLUSH.
        clr(); mem_ades = 1; mem_pc = 32'h100; mem_bva = 32'h203; id_sys = 1; id_pc = 32'h108;
        tick(); tick();
        clr(); cp0_addr = 5'd8; tick(); cp0_addr = 5'd13; tick(); cp0_addr = 5'd14; tick();

        // Hardware interrupt 0 with IE and IM2, then held high while EXL=1.
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; mem_valid = 1; mem_pc = 32'h80;
        repeat (6) begin cp0_addr = 5'd13; tick(); end
        cp0_addr = 5'd14; tick(); hw_int = 0; clr(); tick();

        // ERET to a written EPC, then ERET together with overflow.
        mtc0(5'd14, 32'h200);
        mem_eret = 1; tick(); clr(); cp0_addr = 5'd12; tick();
        mem_eret = 1; exe_ov = 1; exe_pc = 32'h44; tick(); clr(); cp0_addr = 5'd12; tick();

        // Timer: Compare=5, Count=0, watch Cause.IP[7], then re-arm Compare.
        mtc0(5'd11, 32'd5); mtc0(5'd9, 32'd0);
        repeat (14) begin cp0_addr = 5'd13; tick(); end
        mtc0(5'd11, 32'd100);
        cp0_addr = 5'd13; tick(); tick();

        // Reset while the redirect pulse is up: outputs must drop immediately.
        clr(); exe_ov = 1; exe_pc = 32'h48; tick();
        clr(); reset = 0; tick(); tick();
        reset = 1; cp0_addr = 5'd12; tick(); tick();

        // Randomized traffic.
        repeat (3000) begin rand_inputs(); tick(); end
        clr(); hw_int = 0; tick(); tick();

        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Exception and CP0 controller for the 5-stage MIPS pipeline (FETCH/DECODE/EXE/MEM/WB).
- Collects per-stage exception flags and interrupt sources.
- Picks exactly one event per cycle by priority and owns the CP0 registers (BadVAddr, Count, Compare, Status, Cause, EPC).
- Sequences a pipeline flush and PC redirect to the exception vector or, on ERET, to EPC.
- Serves MTC0/MFC0 accesses.

Parameters:
EXC_VECTOR, 32'hBFC0_0380, redirect target on any exception/interrupt
STATUS_RST, 32'h0040_0000, Status reset value (BEV=1, IE=0, EXL=0)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
if_adel  in  1  fetch address error on jump target (already valid-qualified)
if_pc  in  32  faulting fetch address
id_ri / id_sys / id_bp  in  1 each  reserved instr / syscall / break in DECODE
id_pc  in  32  PC of DECODE instruction
exe_ov  in  1  arithmetic overflow in EXE
exe_pc  in  32  PC of EXE instruction
mem_valid  in  1  MEM stage holds a live instruction
mem_adel / mem_ades  in  1 each  load / store address error
mem_pc  in  32  PC of MEM instruction
mem_bva  in  32  faulting data address
mem_eret  in  1  ERET in MEM
hw_int  in  6  external interrupt lines, level-sensitive
cp0_wen  in  1  MTC0 write from WB
cp0_addr  in  5  CP0 register number
cp0_sel  in  3  CP0 select
cp0_wdata  in  32  MTC0 data
cp0_rdata  out  32  MFC0 read data (combinational)
flush  out  1  clear all pipeline stage registers
redirect  out  1  load redirect_pc into PC
redirect_pc  out  32  new PC

Behaviour:
- Reset (async, reset=0): state=IDLE, flush=0, redirect=0, redirect_pc=0, Status=STATUS_RST, all other CP0 regs=0, count toggle=0.
- Interrupt pending: int_req = Status.IE & ~Status.EXL & |(Status.IM[7:0] & Cause.IP[7:0]) & mem_valid.
- Cause.IP[6:2] = hw_int[4:0], sampled every cycle.
- Cause.IP[7] = hw_int[5] | timer_pending.
- Cause.IP[1:0] is software-written.
- Priority (highest first), with ExcCode/EPC/BadVAddr per source:
  1. int_req: ExcCode 0, EPC=mem_pc.
  2. mem_adel: 4, EPC=mem_pc, BVA=mem_bva.
  3. mem_ades: 5, EPC=mem_pc, BVA=mem_bva.
  4. exe_ov: 12, EPC=exe_pc.
  5. id_ri: 10, EPC=id_pc.
  6. id_sys: 8, EPC=id_pc.
  7. id_bp: 9, EPC=id_pc.
  8. if_adel: 4, EPC=if_pc, BVA=if_pc.
  9. mem_eret: lowest priority; ignored if any of the above fires.
- FSM states: IDLE, FLUSH.
- IDLE with a source active, at the edge:
  - Update CP0: Status.EXL=1, Cause.ExcCode, EPC (and BadVAddr where listed).
  - Set flush=1, redirect=1, redirect_pc=EXC_VECTOR, go to FLUSH.
- IDLE with ERET, at the edge: Status.EXL=0, flush=1, redirect=1, redirect_pc=EPC (value before any same-cycle MTC0), go to FLUSH.
- FLUSH: flush=0, redirect=0, always returns to IDLE next edge. All exception, interrupt and ERET inputs are ignored (they come from flushed instructions). Latency from detection to redirect pulse is 1 cycle; the pulse is exactly 1 cycle.
- Exceptions taken while EXL=1: still taken and EPC overwritten (no nesting guard beyond interrupt masking).
- Cause.BD: not implemented, reads 0.
- MTC0 (cp0_sel=0; cp0_wen ignored when cp0_sel≠0), writable fields:
  - Count(9): all bits.
  - Compare(11): all bits; the write also clears timer_pending.
  - Status(12): bits 15:8, 1, 0.
  - Cause(13): bits 9:8.
  - EPC(14): all bits.
  - BadVAddr(8): read-only.
- MTC0 and an exception in the same cycle: apply the MTC0 first, then the exception fields override (EPC, EXL, ExcCode, BadVAddr). Writes to other fields persist.
- Count increments every second cycle (toggle bit). An MTC0 to Count wins over the increment.
- Timer: when Count==Compare and Compare≠0, set timer_pending. It stays set until Compare is written.
- cp0_rdata: the selected register when cp0_sel=0 and the address is implemented, else 0.
- Reset mid-flush: all outputs drop to reset values immediately.

Test Plan:
- Reset release, no events -> flush=0, redirect=0; MFC0 reg 12 returns 32'h0040_0000; reg 9 reads 1 after 2 cycles.
- exe_ov=1, exe_pc=32'h0000_0040 for 1 cycle -> next cycle flush=redirect=1 with redirect_pc=32'hBFC0_0380; Cause[6:2]=12, EPC=32'h40, Status.EXL=1; pulse lasts exactly one cycle.
- mem_ades (mem_pc=32'h100, mem_bva=32'h203) with id_sys (id_pc=32'h108) in the same cycle -> ExcCode=5, EPC=32'h100, BadVAddr=32'h203; no second redirect from the syscall during FLUSH.
- MTC0 Status=32'h0000_0401, then hw_int[0]=1 while mem_valid=1, mem_pc=32'h80 -> ExcCode=0, EPC=32'h80, EXL=1; holding hw_int high takes no further interrupt while EXL=1.
- MTC0 EPC=32'h0000_0200, then mem_eret=1 -> redirect_pc=32'h200, EXL=0; ERET together with exe_ov -> redirect_pc=EXC_VECTOR, EXL=1.
- MTC0 Compare=5, Count=0 -> Cause.IP[7]=1 after Count reaches 5 (≈10 cycles); MTC0 Compare=100 -> IP[7]=0. Assert reset=0 during FLUSH -> flush and redirect drop to 0 the same cycle.
